ram_ahb_arbiter: RTL and testbench

- Two-master arbiter and transfer sequencer in front of the single-slave RAM (ram_top) AHB-style port.
- Shares the port between the instruction-fetch master (m0) and the load/store master (m1).
- Converts each simple request/grant/done transaction into one address phase plus one data phase on the slave bus.
- Supports one outstanding transfer; round-robin or fixed-priority arbitration; hready timeout protection.

---
 rtl/ram_ahb_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ram_ahb_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ahb_arbiter.sv
// Two-master arbiter and single-outstanding transfer sequencer for the RAM AHB-style slave port.
// Each granted request becomes one address phase and one data phase; every output is registered.
module ram_ahb_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_write,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_write,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic          hsel,
  output logic [AW-1:0] haddr,
  output logic          hwrite,
  output logic [DW-1:0] hwdata,
  input  logic          hready,
  input  logic          hresp,
  input  logic [DW-1:0] hrdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  // GRANT is the cycle the gnt pulse is visible; the bus address phase follows it.
  typedef enum logic [1:0] {IDLE, GRANT, ADDR, DATA} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic                 last_reg, last_next;
  logic                 own_reg, own_next;
  logic [AW-1:0]        addr_reg, addr_next;
  logic                 write_reg, write_next;
  logic [DW-1:0]        wdata_reg, wdata_next;

  logic [1:0]           gnt_reg, gnt_next;
  logic [1:0]           done_reg, done_next;
  logic [1:0]           err_reg, err_next;
  logic [1:0][DW-1:0]   rdata_reg, rdata_next;
  logic                 hsel_reg, hsel_next;
  logic [AW-1:0]        haddr_reg, haddr_next;
  logic                 hwrite_reg, hwrite_next;
  logic [DW-1:0]        hwdata_reg, hwdata_next;

  logic                 pick;
  logic [DW-1:0]        wdata_out;

  // Round-robin favours the master not granted last; fixed priority always favours m0.
  always_comb begin
    pick = 1'b0;
    if (m0_req && m1_req)
      pick = (PRIO_MODE == 1) ? 1'b0 : ~last_reg;
    else if (m1_req)
      pick = 1'b1;
  end

  assign wdata_out = write_reg ? wdata_reg : '0;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    last_next   = last_reg;
    own_next    = own_reg;
    addr_next   = addr_reg;
    write_next  = write_reg;
    wdata_next  = wdata_reg;
    gnt_next    = '0;
    done_next   = '0;
    err_next    = '0;
    rdata_next  = '0;
    hsel_next   = 1'b0;
    haddr_next  = '0;
    hwrite_next = 1'b0;
    hwdata_next = '0;
    case (state_reg)
      IDLE: begin
        if (m0_req || m1_req) begin
          own_next       = pick;
          last_next      = pick;
          addr_next      = pick ? m1_addr  : m0_addr;
          write_next     = pick ? m1_write : m0_write;
          wdata_next     = pick ? m1_wdata : m0_wdata;
          gnt_next[pick] = 1'b1;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        hsel_next   = 1'b1;
        haddr_next  = addr_reg;
        hwrite_next = write_reg;
        state_next  = ADDR;
      end
      ADDR: begin
        hwdata_next = wdata_out;
        cnt_next    = '0;
        state_next  = DATA;
      end
      DATA: begin
        if (hready) begin
          done_next[own_reg]  = 1'b1;
          rdata_next[own_reg] = write_reg ? '0 : hrdata;
          err_next[own_reg]   = hresp;
          state_next          = IDLE;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          // Forced completion; anything the slave returns later lands in IDLE and is ignored.
          done_next[own_reg] = 1'b1;
          err_next[own_reg]  = 1'b1;
          state_next         = IDLE;
        end else begin
          cnt_next    = cnt_reg + CW'(1);
          hwdata_next = wdata_out;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      last_reg   <= 1'b1;
      own_reg    <= 1'b0;
      addr_reg   <= '0;
      write_reg  <= 1'b0;
      wdata_reg  <= '0;
      gnt_reg    <= '0;
      done_reg   <= '0;
      err_reg    <= '0;
      rdata_reg  <= '0;
      hsel_reg   <= 1'b0;
      haddr_reg  <= '0;
      hwrite_reg <= 1'b0;
      hwdata_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      last_reg   <= last_next;
      own_reg    <= own_next;
      addr_reg   <= addr_next;
      write_reg  <= write_next;
      wdata_reg  <= wdata_next;
      gnt_reg    <= gnt_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      rdata_reg  <= rdata_next;
      hsel_reg   <= hsel_next;
      haddr_reg  <= haddr_next;
      hwrite_reg <= hwrite_next;
      hwdata_reg <= hwdata_next;
    end
  end

  assign m0_gnt   = gnt_reg[0];
  assign m0_done  = done_reg[0];
  assign m0_rdata = rdata_reg[0];
  assign m0_err   = err_reg[0];
  assign m1_gnt   = gnt_reg[1];
  assign m1_done  = done_reg[1];
  assign m1_rdata = rdata_reg[1];
  assign m1_err   = err_reg[1];
  assign hsel     = hsel_reg;
  assign haddr    = haddr_reg;
  assign hwrite   = hwrite_reg;
  assign hwdata   = hwdata_reg;

endmodule

// File: tb/tb_ram_ahb_arbiter.sv
// Directed bench for ram_ahb_arbiter: a small RAM slave model plus a grant/done scoreboard.
// A second instance with fixed priority shares the master inputs for the priority scenario.
module tb_ram_ahb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        m0_req = 0, m0_write = 0, m1_req = 0, m1_write = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic        hready = 1'b1, hresp = 1'b0;
  logic [31:0] hrdata = 32'h0;

  logic        p_m0_gnt, p_m0_done, p_m0_err, p_m1_gnt, p_m1_done, p_m1_err;
  logic [31:0] p_m0_rdata, p_m1_rdata;
  logic        p_hsel, p_hwrite;
  logic [31:0] p_haddr, p_hwdata;

  ram_ahb_arbiter #(.AW(32), .DW(32), .PRIO_MODE(0), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .hsel(hsel), .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  ram_ahb_arbiter #(.AW(32), .DW(32), .PRIO_MODE(1), .TIMEOUT(16)) dut_p (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
    .m0_gnt(p_m0_gnt), .m0_done(p_m0_done), .m0_rdata(p_m0_rdata), .m0_err(p_m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
    .m1_gnt(p_m1_gnt), .m1_done(p_m1_done), .m1_rdata(p_m1_rdata), .m1_err(p_m1_err),
    .hsel(p_hsel), .haddr(p_haddr), .hwrite(p_hwrite), .hwdata(p_hwdata),
    .hready(1'b1), .hresp(1'b0), .hrdata(32'hABCD_0000)
  );

  typedef struct {
    bit          mst;
    logic [31:0] rdata;
    bit          err;
    int          lat;
  } done_t;

  done_t done_q[$];
  bit    gnt_q[$];
  bit    pgnt_q[$];
  bit    pchk = 1'b0;
  int    n_assert = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    hsel_cyc = 0;
  int    done_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave model: captures the address phase, answers reads from mem, commits writes in the data phase.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] s_addr = 32'h0;
  bit          wr_pend = 1'b0;
  always @(negedge clk) begin
    if (wr_pend) begin
      mem[s_addr] = hwdata;
      wr_pend = 1'b0;
    end
    if (hsel) begin
      s_addr  = haddr;
      wr_pend = hwrite;
    end
    hrdata = mem.exists(s_addr) ? mem[s_addr] : 32'h0;
  end

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    done_t e;
    bit    g;
    cyc++;
    if (!rst) begin
      if (hsel) hsel_cyc = cyc;
      if (m0_gnt || m1_gnt) begin
        chk("gnt_exclusive", {63'd0, m0_gnt & m1_gnt}, 64'd0);
        if (gnt_q.size() == 0) chk("gnt_unexpected", gnt_q.size(), 64'd1);
        else begin
          g = gnt_q.pop_front();
          chk("gnt_owner", {63'd0, m1_gnt}, {63'd0, g});
        end
      end
      if (pchk && (p_m0_gnt || p_m1_gnt)) begin
        if (pgnt_q.size() == 0) chk("pgnt_unexpected", pgnt_q.size(), 64'd1);
        else begin
          g = pgnt_q.pop_front();
          chk("pgnt_owner", {63'd0, p_m1_gnt}, {63'd0, g});
        end
      end
      if (pchk && !p_hsel) chk("p_bus_idle", {31'd0, p_hwrite, p_haddr}, 64'd0);
      if (pchk) chk("p_hwdata_read", {32'd0, p_hwdata}, 64'd0);
      if (pchk && (p_m0_done || p_m1_done))
        chk("p_done_data", {p_m0_err | p_m1_err, p_m0_rdata | p_m1_rdata}, {1'b0, 32'hABCD_0000});
      if (m0_done || m1_done) begin
        done_cnt++;
        chk("done_exclusive", {63'd0, m0_done & m1_done}, 64'd0);
        if (done_q.size() == 0) chk("done_unexpected", done_q.size(), 64'd1);
        else begin
          e = done_q.pop_front();
          chk("done_owner", {63'd0, m1_done}, {63'd0, e.mst});
          chk("done_rdata", {32'd0, e.mst ? m1_rdata : m0_rdata}, {32'd0, e.rdata});
          chk("done_err", {63'd0, e.mst ? m1_err : m0_err}, {63'd0, e.err});
          chk("other_quiet", {31'd0, e.mst ? m0_err : m1_err, e.mst ? m0_rdata : m1_rdata}, 64'd0);
          chk("done_latency", cyc - hsel_cyc, e.lat);
          $display("[%0t] done m%0d rdata=%08h err=%0d latency=%0d", $time, e.mst,
                   e.mst ? m1_rdata : m0_rdata, e.mst ? m1_err : m0_err, cyc - hsel_cyc);
        end
      end
    end
  end

  task automatic wait_gnt(input bit m);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m ? m1_gnt : m0_gnt) begin
        seen = 1'b1;
        break;
      end
    end
    chk("gnt_wait", {63'd0, seen}, 64'd1);
  endtask

  task automatic request(input bit m, input logic [31:0] a, input bit w, input logic [31:0] d);
    if (m) begin
      m1_req = 1'b1; m1_addr = a; m1_write = w; m1_wdata = d;
    end else begin
      m0_req = 1'b1; m0_addr = a; m0_write = w; m0_wdata = d;
    end
    wait_gnt(m);
    if (m) m1_req = 1'b0;
    else   m0_req = 1'b0;
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (done_q.size() == 0 && gnt_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", done_q.size() + gnt_q.size(), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    int g;
    int dc;
    mem[32'h0000_0100] = 32'hCAFE_0001;
    repeat (3) @(negedge clk);
    chk("rst_m0", {31'd0, m0_gnt, m0_done, m0_err, m0_rdata}, 64'd0);
    chk("rst_m1", {31'd0, m1_gnt, m1_done, m1_err, m1_rdata}, 64'd0);
    chk("rst_bus", {31'd0, hsel, hwrite, haddr}, 64'd0);
    chk("rst_hwdata", {32'd0, hwdata}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // m0 write with phase-by-phase bus checks
    gnt_q.push_back(1'b0);
    done_q.push_back('{mst: 1'b0, rdata: 32'h0, err: 1'b0, lat: 2});
    request(1'b0, 32'hF0F0_F0F0, 1'b1, 32'h1234_5678);
    @(negedge clk);
    chk("addr_phase", {31'd0, hsel, hwrite, haddr}, {31'd0, 1'b1, 1'b1, 32'hF0F0_F0F0});
    @(negedge clk);
    chk("data_phase", {31'd0, hsel, hwdata}, {32'd0, 32'h1234_5678});
    drain(10);

    // m1 reads back what m0 wrote
    gnt_q.push_back(1'b1);
    done_q.push_back('{mst: 1'b1, rdata: 32'h1234_5678, err: 1'b0, lat: 2});
    request(1'b1, 32'hF0F0_F0F0, 1'b0, 32'h0);
    drain(10);

    // Both masters requesting: round-robin on dut, fixed priority on dut_p
    gnt_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    pgnt_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    done_q.push_back('{mst: 1'b0, rdata: 32'h1234_5678, err: 1'b0, lat: 2});
    done_q.push_back('{mst: 1'b1, rdata: 32'hCAFE_0001, err: 1'b0, lat: 2});
    done_q.push_back('{mst: 1'b0, rdata: 32'h1234_5678, err: 1'b0, lat: 2});
    done_q.push_back('{mst: 1'b1, rdata: 32'hCAFE_0001, err: 1'b0, lat: 2});
    done_q.push_back('{mst: 1'b1, rdata: 32'hCAFE_0001, err: 1'b0, lat: 2});
    pchk = 1'b1;
    m0_addr = 32'hF0F0_F0F0; m0_write = 1'b0; m0_wdata = 32'h0;
    m1_addr = 32'h0000_0100; m1_write = 1'b0; m1_wdata = 32'h0;
    m0_req = 1'b1; m1_req = 1'b1;
    g = 0;
    for (int i = 0; i < 40 && g < 4; i++) begin
      @(negedge clk);
      if (m0_gnt || m1_gnt) g++;
    end
    chk("rr_grants_seen", g, 64'd4);
    m0_req = 1'b0;
    wait_gnt(1'b1);
    m1_req = 1'b0;
    drain(20);
    chk("pgnt_drain", pgnt_q.size(), 64'd0);
    pchk = 1'b0;

    // Slave never ready: forced error completion, then a late hready is ignored
    hready = 1'b0;
    gnt_q.push_back(1'b0);
    done_q.push_back('{mst: 1'b0, rdata: 32'h0, err: 1'b1, lat: 17});
    request(1'b0, 32'h0000_0200, 1'b0, 32'h0);
    drain(40);
    dc = done_cnt;
    hready = 1'b1;
    @(negedge clk);
    hready = 1'b0;
    repeat (4) @(negedge clk);
    chk("late_hready", done_cnt, dc);
    hready = 1'b1;

    // Slave error response on a write
    hresp = 1'b1;
    gnt_q.push_back(1'b1);
    done_q.push_back('{mst: 1'b1, rdata: 32'h0, err: 1'b1, lat: 2});
    request(1'b1, 32'h0000_0300, 1'b1, 32'hAAAA_5555);
    drain(10);
    hresp = 1'b0;

    // Reset asserted during the data phase of a stalled write
    hready = 1'b0;
    gnt_q.push_back(1'b1);
    request(1'b1, 32'h0000_0400, 1'b1, 32'h5A5A_5A5A);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_hwdata", {32'd0, hwdata}, {32'd0, 32'h5A5A_5A5A});
    dc = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_bus", {31'd0, hsel, hwrite, haddr}, 64'd0);
    chk("async_rst_hwdata", {32'd0, hwdata}, 64'd0);
    chk("async_rst_m1", {31'd0, m1_gnt, m1_done, m1_err, m1_rdata}, 64'd0);
    chk("async_rst_m0", {31'd0, m0_gnt, m0_done, m0_err, m0_rdata}, 64'd0);
    hready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_done_after_rst", done_cnt, dc);

    gnt_q.push_back(1'b1);
    done_q.push_back('{mst: 1'b1, rdata: 32'hCAFE_0001, err: 1'b0, lat: 2});
    request(1'b1, 32'h0000_0100, 1'b0, 32'h0);
    drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
